// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam logic        START_LVL = 1'b0;
    localparam logic        STOP_LVL  = 1'b1;
    localparam logic        IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; strobes bit_end_o on the last cycle of each serial bit.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic bit_end_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] TermCnt = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == TermCnt);

    // Wrapping at terminal count restarts the period for whichever state comes next.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, 8 data bits LSB-first, stop bit, all outputs registered.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       serial_out_o
);

    uart_state_e state_q;
    logic [7:0]  shift_q;
    logic [2:0]  idx_q;
    logic        serial_q;
    logic        busy_q;
    logic        done_q;
    logic        bit_end;

    // Timer is held at zero while idle so the start bit gets a full period.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == StIdle),
        .bit_end_o(bit_end)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            serial_q <= IDLE_LVL;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (tx_start_i) begin
                        shift_q  <= tx_data_i;
                        idx_q    <= '0;
                        serial_q <= START_LVL;
                        busy_q   <= 1'b1;
                        state_q  <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        idx_q    <= '0;
                        serial_q <= shift_q[0];
                        state_q  <= StData;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (idx_q == 3'(DATA_BITS - 1)) begin
                            serial_q <= STOP_LVL;
                            state_q  <= StStop;
                        end else begin
                            idx_q    <= idx_q + 3'd1;
                            serial_q <= shift_q[1];
                        end
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        serial_q <= IDLE_LVL;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tx_busy_o    = busy_q;
    assign tx_done_o    = done_q;
    assign serial_out_o = serial_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at 10 clocks per bit, checked cycle by cycle.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       serial_out;

    int n_vec;
    int n_err;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(10)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tx_start_i  (tx_start),
        .tx_data_i   (tx_data),
        .tx_busy_o   (tx_busy),
        .tx_done_o   (tx_done),
        .serial_out_o(serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " serial"}, serial_out, 1'b1);
        check_eq({tag, " busy"}, tx_busy, 1'b0);
        check_eq({tag, " done"}, tx_done, 1'b0);
    endtask

    // Precondition: at a negedge with tx_start/tx_data already driven for the accept edge.
    // exp_bits holds the frame in line order, first bit in the MSB.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] exp_bits,
                             input int intr_n, input bit chain, input logic [7:0] chain_d);
        @(negedge clk);
        tx_start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            check_eq($sformatf("%02h c%0d serial", d, n), serial_out, exp_bits[9 - n / 10]);
            check_eq($sformatf("%02h c%0d busy", d, n), tx_busy, 1'b1);
            check_eq($sformatf("%02h c%0d done", d, n), tx_done, 1'b0);
            if (n == intr_n) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
        end
        check_eq($sformatf("%02h end done", d), tx_done, 1'b1);
        check_eq($sformatf("%02h end busy", d), tx_busy, 1'b0);
        check_eq($sformatf("%02h end serial", d), serial_out, 1'b1);
        if (chain) begin
            tx_start = 1'b1;
            tx_data  = chain_d;
        end else begin
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                check_idle($sformatf("%02h post%0d", d, i));
            end
        end
    endtask

    task automatic launch(input logic [7:0] d);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // Reset takes effect before any clock edge.
        #3 rst = 1'b1;
        #1 check_idle("por");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_rst");

        // 0xA5 with a rejected request at cycle 35.
        launch(8'hA5);
        run_frame(8'hA5, 10'b0101001011, 35, 1'b0, 8'h00);

        // Back-to-back: 0x3C requested in the tx_done cycle.
        launch(8'hA5);
        run_frame(8'hA5, 10'b0101001011, -1, 1'b1, 8'h3C);
        run_frame(8'h3C, 10'b0001111001, -1, 1'b0, 8'h00);

        // Extremes.
        launch(8'h00);
        run_frame(8'h00, 10'b0000000001, -1, 1'b0, 8'h00);
        launch(8'hFF);
        run_frame(8'hFF, 10'b0111111111, -1, 1'b0, 8'h00);

        // Reset during data bit 4 of 0x00.
        launch(8'h00);
        @(negedge clk);
        tx_start = 1'b0;
        repeat (54) @(negedge clk);
        check_eq("mid bit4 serial", serial_out, 1'b0);
        check_eq("mid bit4 busy", tx_busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_idle("mid_rst");
        @(negedge clk);
        check_idle("mid_rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_rst_rel");
        launch(8'h81);
        run_frame(8'h81, 10'b0100000011, -1, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
